// File: rtl/bit_scan_pkg.sv
// Shared types and helpers for the bit-scan serializer.
package bit_scan_pkg;

  typedef enum logic {IDLE, SCAN} scan_state_t;

  // Widest word the helper below handles; callers cast to and from this width.
  localparam int SCAN_MAX_W = 64;

  function automatic logic [SCAN_MAX_W-1:0] clear_bit(input logic [SCAN_MAX_W-1:0] word,
                                                      input int unsigned           pos);
    logic [SCAN_MAX_W-1:0] res;
    res      = word;
    res[pos] = 1'b0;
    return res;
  endfunction

endpackage

// File: rtl/priority_encoder.sv
// Lowest-set-bit priority encoder: pos is the smallest set index, valid when any bit is set.
module priority_encoder #(
  parameter  int DATA_WIDTH = 8,
  localparam int POS_W      = $clog2(DATA_WIDTH)
) (
  input  logic [DATA_WIDTH-1:0] data,
  output logic [POS_W-1:0]      pos,
  output logic                  valid
);

  always_comb begin
    pos   = '0;
    valid = 1'b0;
    // Walking downward lets the lowest set bit be the last one written.
    for (int i = DATA_WIDTH - 1; i >= 0; i--) begin
      if (data[i]) begin
        pos   = POS_W'(i);
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/bit_scan_serializer.sv
// Serialises the set-bit indices of a multi-hot word, lowest first, over valid/ready.
// Optional macro BIT_SCAN_ZERO_BEAT_EN: zero words yield one out_empty beat instead of being dropped.
module bit_scan_serializer
  import bit_scan_pkg::*;
#(
  parameter  int DATA_WIDTH = 8,
  localparam int POS_W      = $clog2(DATA_WIDTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [POS_W-1:0]      out_pos,
  output logic                  out_last,
  output logic                  out_valid,
`ifdef BIT_SCAN_ZERO_BEAT_EN
  output logic                  out_empty,
`endif
  input  logic                  out_ready,
  output logic                  busy
);

  scan_state_t           state_q, state_d;
  logic [DATA_WIDTH-1:0] word_q, word_d;
  logic [POS_W-1:0]      enc_pos;
  logic                  enc_valid;
  logic                  beat;
  logic                  accept;

  priority_encoder #(.DATA_WIDTH(DATA_WIDTH)) u_enc (
    .data  (word_q),
    .pos   (enc_pos),
    .valid (enc_valid)
  );

`ifdef BIT_SCAN_ZERO_BEAT_EN
  logic empty_q, empty_d;
  assign out_empty = (state_q == SCAN) && empty_q;
  assign out_valid = (state_q == SCAN) && (enc_valid || empty_q);
`else
  assign out_valid = (state_q == SCAN) && enc_valid;
`endif

  // An empty held word also reads as "last" here, which the zero-beat response relies on.
  assign out_last = (state_q == SCAN) && ~|(word_q & (word_q - DATA_WIDTH'(1)));
  assign out_pos  = enc_pos;
  assign busy     = (state_q == SCAN);
  assign beat     = out_valid && out_ready;
  assign in_ready = (state_q == IDLE) || (beat && out_last);
  assign accept   = in_valid && in_ready;

  always_comb begin
    state_d = state_q;
    word_d  = word_q;
`ifdef BIT_SCAN_ZERO_BEAT_EN
    empty_d = empty_q;
`endif
    if (beat) begin
      word_d = DATA_WIDTH'(clear_bit(SCAN_MAX_W'(word_q), 32'(enc_pos)));
      if (out_last) begin
        state_d = IDLE;
`ifdef BIT_SCAN_ZERO_BEAT_EN
        empty_d = 1'b0;
`endif
      end
    end
    if (accept) begin
      if (in_data != '0) begin
        word_d  = in_data;
        state_d = SCAN;
`ifdef BIT_SCAN_ZERO_BEAT_EN
        empty_d = 1'b0;
`endif
      end
`ifdef BIT_SCAN_ZERO_BEAT_EN
      else begin
        word_d  = '0;
        state_d = SCAN;
        empty_d = 1'b1;
      end
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      word_q  <= '0;
`ifdef BIT_SCAN_ZERO_BEAT_EN
      empty_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      word_q  <= word_d;
`ifdef BIT_SCAN_ZERO_BEAT_EN
      empty_q <= empty_d;
`endif
    end
  end

endmodule

// File: tb/tb_bit_scan_serializer.sv
// Directed plus randomized bench for bit_scan_serializer against a queue-of-beats reference model.
module tb_bit_scan_serializer;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [W-1:0] in_data = '0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [2:0]   out_pos;
  logic         out_last;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic         busy;
`ifdef BIT_SCAN_ZERO_BEAT_EN
  logic         out_empty;
`endif

  bit_scan_serializer #(.DATA_WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_pos   (out_pos),
    .out_last  (out_last),
    .out_valid (out_valid),
`ifdef BIT_SCAN_ZERO_BEAT_EN
    .out_empty (out_empty),
`endif
    .out_ready (out_ready),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int pos;
    bit last;
    bit empty;
  } beat_t;

  beat_t q[$];
  int    n_cmp = 0;
  int    n_err = 0;
  int    n_beats = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // Expected response to an accepted word: one beat per set bit, ascending.
  task automatic push_word(input logic [W-1:0] d);
    int cnt, k;
    cnt = $countones(d);
    k   = 0;
    if (d == '0) begin
`ifdef BIT_SCAN_ZERO_BEAT_EN
      q.push_back('{0, 1'b1, 1'b1});
`endif
    end else begin
      for (int i = 0; i < W; i++) begin
        if (d[i]) begin
          k++;
          q.push_back('{i, k == cnt, 1'b0});
        end
      end
    end
  endtask

  // One cycle, entered and left on a falling edge.
  task automatic step(input logic v, input logic [W-1:0] d, input logic r);
    logic exp_rdy;
    check("out_valid", 32'(out_valid), 32'(q.size() != 0));
    check("busy", 32'(busy), 32'(q.size() != 0));
    if (q.size() != 0) begin
      check("out_pos", 32'(out_pos), 32'(q[0].pos));
      check("out_last", 32'(out_last), 32'(q[0].last));
`ifdef BIT_SCAN_ZERO_BEAT_EN
      check("out_empty", 32'(out_empty), 32'(q[0].empty));
`endif
    end
    in_valid  = v;
    in_data   = d;
    out_ready = r;
    #1;
    exp_rdy = (q.size() == 0) || (r && q[0].last);
    check("in_ready", 32'(in_ready), 32'(exp_rdy));
    if (q.size() != 0 && r) begin
      void'(q.pop_front());
      n_beats++;
    end
    if (v && exp_rdy) push_word(d);
    @(negedge clk);
  endtask

  task automatic pulse_reset();
    in_valid  = 1'b0;
    out_ready = 1'b0;
    rst       = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    q.delete();
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
  endtask

  initial begin
    logic [W-1:0] d;
    int           sel;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("init_out_valid", 32'(out_valid), 32'd0);
    check("init_out_pos", 32'(out_pos), 32'd0);
    check("init_out_last", 32'(out_last), 32'd0);
    check("init_busy", 32'(busy), 32'd0);
    check("init_in_ready", 32'(in_ready), 32'd1);
`ifdef BIT_SCAN_ZERO_BEAT_EN
    check("init_out_empty", 32'(out_empty), 32'd0);
`endif

    // Three-bit word with consumer always ready.
    step(1'b1, 8'b1010_0100, 1'b1);
    repeat (3) step(1'b0, '0, 1'b1);

    // Single-bit word, next word presented on its final beat.
    step(1'b1, 8'b0001_0000, 1'b1);
    step(1'b1, 8'b0000_0011, 1'b1);
    repeat (2) step(1'b0, '0, 1'b1);

    // Stall for three cycles before releasing.
    step(1'b1, 8'b1100_0000, 1'b1);
    repeat (3) step(1'b0, '0, 1'b0);
    repeat (2) step(1'b0, '0, 1'b1);

    // All ones.
    n_beats = 0;
    step(1'b1, 8'hFF, 1'b1);
    repeat (8) step(1'b0, '0, 1'b1);
    check("ff_beats", 32'(n_beats), 32'd8);
    step(1'b0, '0, 1'b1);

    // Zero word.
    step(1'b1, 8'h00, 1'b1);
    repeat (2) step(1'b0, '0, 1'b1);

    // Reset after the first beat of a two-bit word.
    step(1'b1, 8'b0110_0000, 1'b1);
    step(1'b0, '0, 1'b1);
    pulse_reset();
    repeat (2) step(1'b0, '0, 1'b1);

    // Random traffic with random back-pressure.
    for (int c = 0; c < 3000; c++) begin
      sel = int'($urandom_range(0, 9));
      if (sel == 0)      d = '0;
      else if (sel <= 2) d = W'(1) << $urandom_range(0, W - 1);
      else if (sel == 3) d = '1;
      else               d = W'($urandom);
      if (c % 997 == 500) pulse_reset();
      else step(1'($urandom_range(0, 1)), d, $urandom_range(0, 3) != 0);
    end
    repeat (12) step(1'b0, '0, 1'b1);
    check("drained", 32'(q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
